// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, sequencer
// phases and default bus widths.
package cpu_pkg;

   localparam int AW_DEF = 5;
   localparam int DW_DEF = 8;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_e;

   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8
   } state_e;

   // Opcodes that read an operand from memory and load the accumulator.
   function automatic logic is_aluop(input opcode_e op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/seq_ctrl.sv
// Eight-phase control sequencer: fetches an instruction into the IR,
// decodes it and strobes the PC, memory and accumulator controls.
module seq_ctrl
   import cpu_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic [DW-1:0] mem_data,
   input  logic          zero,
   output logic [AW-1:0] adir,
   output logic          ldpc,
   output logic          incpc,
   output logic          sel,
   output logic          rd,
   output logic          wr,
   output logic          ld_ir,
   output logic          ld_ac,
   output logic          data_oe,
   output logic          halt,
   output logic [2:0]    opcode
);

   state_e        state_q, state_d;
   logic [DW-1:0] ir_q, ir_d;
   opcode_e       op;

   assign op     = opcode_e'(ir_q[DW-1 -: 3]);
   assign opcode = ir_q[DW-1 -: 3];
   assign adir   = ir_q[AW-1:0];

   // State and instruction register; reset restarts the fetch and clears IR.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= INST_ADDR;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Phase sequencing; IR captures the bus only at the end of INST_LOAD.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         INST_ADDR:  state_d = INST_FETCH;
         INST_FETCH: state_d = INST_LOAD;
         INST_LOAD: begin
            ir_d    = mem_data;
            state_d = IDLE;
         end
         IDLE:       state_d = OP_ADDR;
         OP_ADDR:    state_d = (op == HLT) ? HALTED : OP_FETCH;
         OP_FETCH:   state_d = ALU_OP;
         ALU_OP:     state_d = STORE;
         STORE:      state_d = INST_ADDR;
         HALTED:     state_d = HALTED;
         default:    state_d = INST_ADDR;
      endcase
   end

   // Output decode; while rst is high the INST_ADDR decode is forced so no
   // strobe from an interrupted instruction can reach the datapath.
   always_comb begin
      ldpc    = 1'b0;
      incpc   = 1'b0;
      sel     = 1'b0;
      rd      = 1'b0;
      wr      = 1'b0;
      ld_ir   = 1'b0;
      ld_ac   = 1'b0;
      data_oe = 1'b0;
      halt    = 1'b0;
      if (rst) begin
         sel = 1'b1;
      end else begin
         case (state_q)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               // ld_ir stays high through IDLE for bus timing only.
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               if (op == HLT) halt  = 1'b1;
               else           incpc = 1'b1;
            end
            OP_FETCH: rd = is_aluop(op);
            ALU_OP: begin
               // A taken SKZ skips the next word; JMP overrides the earlier +1.
               rd      = is_aluop(op);
               incpc   = (op == SKZ) && zero;
               ldpc    = (op == JMP);
               data_oe = (op == STO);
            end
            STORE: begin
               rd      = is_aluop(op);
               ld_ac   = is_aluop(op);
               wr      = (op == STO);
               data_oe = (op == STO);
            end
            HALTED:  halt = 1'b1;
            default: sel  = 1'b1;
         endcase
      end
   end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
- Control sequencer for the 8-bit accumulator RISC CPU; the consumer/driver at the other end of the program-counter interface.
- Fetches the instruction addressed by the PC and holds it in an internal instruction register (IR).
- Decodes the IR and drives the PC load/increment strobes, the PC jump address, the memory read/write strobes and the accumulator controls.
- Eight fixed phases per instruction, one cycle each.

Parameters:
- AW, 5, address width (IR operand field and jump address)
- DW, 8, instruction/data width; opcode is always IR[DW-1:DW-3]

Ports:
- pclk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- mem_data  input  DW  instruction/data read bus from memory
- zero  input  1  accumulator-is-zero flag from ALU
- adir  output  AW  jump/operand address = IR[AW-1:0], to PC load input and address mux
- ldpc  output  1  PC load strobe (PC <= adir)
- incpc  output  1  PC increment strobe (PC <= PC+1)
- sel  output  1  address mux select: 1 = PC address, 0 = adir
- rd  output  1  memory read enable
- wr  output  1  memory write strobe
- ld_ir  output  1  IR capture indicator (IR loads on this cycle's edge)
- ld_ac  output  1  accumulator load strobe
- data_oe  output  1  accumulator drives data bus
- halt  output  1  sequencer stopped
- opcode  output  3  IR opcode field, for the ALU

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD | AND | XOR | LDA.
- State register cycles through the phases below, one per pclk:
  - INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7) -> INST_ADDR.
- Outputs are combinational decode of state and IR. All outputs not listed for a phase are 0.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1. IR <= mem_data on the closing edge of this phase.
  - IDLE: sel=1, rd=1, ld_ir=1. IR is not reloaded; ld_ir is held for bus timing only.
  - OP_ADDR:
    - opcode==HLT: halt=1, incpc=0, next state HALTED.
    - otherwise: incpc=1.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; incpc=(opcode==SKZ && zero); ldpc=(opcode==JMP); data_oe=(opcode==STO). zero is sampled in this cycle only.
  - STORE: rd=ALUOP; ld_ac=ALUOP; wr=(opcode==STO); data_oe=(opcode==STO).
  - HALTED: halt=1. All other strobes are 0. Remains here until rst.
- ldpc and incpc are never asserted together. Each is a single-cycle strobe.
- Net PC effect per instruction:
  - non-SKZ/JMP: +1
  - SKZ with zero=1: +2
  - JMP: PC = IR[AW-1:0], because ldpc in ALU_OP overrides the earlier +1.
- adir = IR[AW-1:0] continuously.
- Reset:
  - rst high at any pclk edge, including mid-instruction or in HALTED: state <= INST_ADDR, IR <= 0.
  - While rst is asserted, outputs equal the INST_ADDR decode: sel=1, all else 0, halt=0.
  - The first fetch begins on the first edge after rst deasserts.
- IR=0 after reset is never decoded before INST_LOAD overwrites it, so reset does not halt.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants HLT..JMP (3-bit)
  - state encoding INST_ADDR..STORE plus HALTED (4-bit)
  - AW/DW defaults
- No sub-module; state register, IR and output decode live in seq_ctrl.

Test Plan:
- Reset/fetch: rst=1 for 2 cycles, release, mem_data=8'hA3 (LDA 3) -> sel=1 cycles 0-3; rd asserted from cycle 1; IR=8'hA3 after cycle 2; adir=5'd3; incpc only in cycle 4; rd in 5-7; ld_ac only in cycle 7.
- JMP: mem_data=8'hF4 -> ldpc=1 only in ALU_OP, adir=5'd20, incpc=1 in OP_ADDR, no rd/wr in 5-7.
- SKZ: 8'h20 with zero=1 -> incpc pulses in cycles 4 and 6. Repeat with zero=0 -> incpc only in cycle 4.
- STO: mem_data=8'hC9 -> data_oe=1 in 6-7, wr=1 only in 7, rd=0 in 5-7, sel=0 in 4-7.
- HLT: mem_data=8'h00 -> halt=1 from OP_ADDR onward, no incpc; stays halted 20 cycles; rst pulse -> INST_ADDR, halt=0.
- Mid-op reset: assert rst during ALU_OP of JMP -> ldpc=0 in that cycle's decode, state=INST_ADDR next edge, IR=0.
